// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle execute-stage ALU (alu_seq):
//   - alu_op_t    : 4-bit alucontrol code map produced by the ALU decoder
//   - alu_state_t : sequencer states
//   - SHAMT_W     : shift-amount width taken from b for SLL/SRL
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned SHAMT_W       = $clog2(DEFAULT_WIDTH);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_MUL = 4'b0100,
        OP_DIV = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111,
        OP_NOT = 4'b1000
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } alu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Shared iterative datapath for unsigned shift-add multiply and restoring
// divide, one bit per step, WIDTH steps per operation.
//
// Ports
//   clk, reset : clock, synchronous active-high reset
//   load       : capture operands and clear the accumulator/step counter
//   is_div     : 1 = restoring-divide step, 0 = shift-add multiply step
//   step_i     : advance one iteration
//   a_i, b_i   : multiplier/dividend and multiplicand/divisor
//   lo_o, hi_o : values the shift register and accumulator take after the
//                current step (product low/high, or quotient/remainder once
//                the last step is taken)
//   fin        : the current step is the last one
// -----------------------------------------------------------------------------
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             fin
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        // Multiply: {acc, sr} is the running product; add the multiplicand
        // when the multiplier LSB is set, then shift the pair right.
        sum     = acc_q + {1'b0, (sr_q[0] ? m_q : '0)};
        // Divide: shift the next dividend bit into the partial remainder and
        // trial-subtract; the remainder stays below the divisor, so the MSB
        // of diff is a clean borrow indicator.
        shifted = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
        diff    = shifted - {1'b0, m_q};

        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_d = diff;
                sr_d  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted;
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {1'b0, sum[WIDTH:1]};
            sr_d  = {sum[0], sr_q[WIDTH-1:1]};
        end
    end

    assign lo_o = sr_d;
    assign hi_o = acc_d[WIDTH-1:0];
    assign fin  = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sr_q  <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            acc_q <= '0;
            sr_q  <= a_i;
            m_q   <= b_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-cycle execute-stage ALU. Logic, add/sub, shifts and NOT finish in one
// cycle; MUL and DIV (b != 0) iterate for WIDTH cycles in muldiv_iter.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   start              : request; accepted only in IDLE
//   alucontrol, a, b   : op code and operands, sampled on acceptance
//   busy               : multiply/divide iterating
//   done               : one-cycle pulse, outputs valid
//   result, hi         : primary result / product high or remainder
//   zero, divzero,
//   illegal            : flags, held with the results until the next done
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             divzero,
    output logic             illegal
);

    alu_state_t       state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             divzero_q, divzero_d;
    logic             illegal_q, illegal_d;
    logic             out_we;

    logic [WIDTH-1:0] sc_res;
    logic             sc_illegal;
    logic [SHAMT_W-1:0] shamt;
    logic             b_zero;

    logic             iter_load;
    logic             iter_fin;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    assign shamt  = b[SHAMT_W-1:0];
    assign b_zero = (b == '0);

    // Single-cycle operations
    always_comb begin
        sc_res     = '0;
        sc_illegal = 1'b0;
        case (alucontrol)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_NOT:  sc_res = ~a;
            OP_MUL, OP_DIV: sc_res = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Sequencer and output-register load
    always_comb begin
        state_d   = state_q;
        out_we    = 1'b0;
        iter_load = 1'b0;
        result_d  = '0;
        hi_d      = '0;
        divzero_d = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (alucontrol == OP_MUL) begin
                        state_d   = ST_MUL;
                        iter_load = 1'b1;
                    end else if (alucontrol == OP_DIV && !b_zero) begin
                        state_d   = ST_DIV;
                        iter_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        out_we  = 1'b1;
                        if (alucontrol == OP_DIV) begin
                            result_d  = '1;
                            hi_d      = a;
                            divzero_d = 1'b1;
                        end else begin
                            result_d  = sc_res;
                            illegal_d = sc_illegal;
                        end
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                // The iterator exposes the post-step values, so the final
                // step's result is registered on the same edge it completes.
                if (iter_fin) begin
                    state_d  = ST_DONE;
                    out_we   = 1'b1;
                    result_d = iter_lo;
                    hi_d     = iter_hi;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            divzero_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (out_we) begin
                result_q  <= result_d;
                hi_q      <= hi_d;
                zero_q    <= zero_d;
                divzero_q <= divzero_d;
                illegal_q <= illegal_d;
            end
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (iter_load),
        .is_div (state_q == ST_DIV),
        .step_i (busy),
        .a_i    (a),
        .b_i    (b),
        .lo_o   (iter_lo),
        .hi_o   (iter_hi),
        .fin    (iter_fin)
    );

    assign busy    = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign hi      = hi_q;
    assign zero    = zero_q;
    assign divzero = divzero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Directed and randomized stimulus for alu_seq with a scoreboard queue of
// expected results filled from an independent reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         divzero;
    logic         illegal;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .hi         (hi),
        .zero       (zero),
        .divzero    (divzero),
        .illegal    (illegal)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         divzero;
        logic         illegal;
        int unsigned  lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_res;
    logic [W-1:0] prev_hi;
    logic         prev_zero;
    logic         prev_dz;
    logic         prev_ill;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] p;
        e.res = '0; e.hi = '0; e.divzero = 1'b0; e.illegal = 1'b0; e.lat = 1;
        case (op)
            4'h0: e.res = x & y;
            4'h1: e.res = x | y;
            4'h2: e.res = x + y;
            4'h3: e.res = x - y;
            4'h4: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
                e.lat = W + 1;
            end
            4'h5: begin
                if (y == '0) begin
                    e.res = '1; e.hi = x; e.divzero = 1'b1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.lat = W + 1;
                end
            end
            4'h6: e.res = x << y[4:0];
            4'h7: e.res = x >> y[4:0];
            4'h8: e.res = ~x;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic clear_prev();
        prev_res = '0; prev_hi = '0; prev_zero = 1'b0; prev_dz = 1'b0; prev_ill = 1'b0;
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge after the
    // done cycle, so the next call lands on the earliest legal accept.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit scramble, input int unsigned inject_at);
        exp_t        e;
        int unsigned lat;
        int unsigned bcnt;
        bit          stable;
        sb.push_back(model(op, x, y));
        alucontrol = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0; stable = 1'b1;
        while (done !== 1'b1 && lat <= W + 4) begin
            if (busy === 1'b1) bcnt++;
            if (result !== prev_res || hi !== prev_hi || zero !== prev_zero ||
                divzero !== prev_dz || illegal !== prev_ill) stable = 1'b0;
            if (scramble) begin
                a = $urandom; b = $urandom; alucontrol = 4'($urandom);
            end
            if (inject_at != 0 && lat == inject_at) begin
                alucontrol = OP_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("done_seen",    64'(done), 64'(1));
        chk("latency",      64'(lat), 64'(e.lat));
        chk("busy_cycles",  64'(bcnt), 64'(e.lat - 1));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("held_between", 64'(stable), 64'(1));
        chk("result",       64'(result), 64'(e.res));
        chk("hi",           64'(hi), 64'(e.hi));
        chk("zero",         64'(zero), 64'(e.zero));
        chk("divzero",      64'(divzero), 64'(e.divzero));
        chk("illegal",      64'(illegal), 64'(e.illegal));
        prev_res = e.res; prev_hi = e.hi; prev_zero = e.zero; prev_dz = e.divzero; prev_ill = e.illegal;
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    64'(busy), 64'(0));
        chk({tag, "_done"},    64'(done), 64'(0));
        chk({tag, "_result"},  64'(result), 64'(0));
        chk({tag, "_hi"},      64'(hi), 64'(0));
        chk({tag, "_zero"},    64'(zero), 64'(0));
        chk({tag, "_divzero"}, 64'(divzero), 64'(0));
        chk({tag, "_illegal"}, 64'(illegal), 64'(0));
    endtask

    initial begin : stim
        int unsigned dn;
        int unsigned cnt;
        logic [3:0]   rop;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        reset = 1'b1; start = 1'b0; alucontrol = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        clear_prev();

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(OP_SUB, 32'd5, 32'd5, 1'b0, 0);
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(OP_DIV, 32'd100, 32'd7, 1'b0, 0);
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0, 0);
        run_op(OP_SLL, 32'd1, 32'h21, 1'b0, 0);
        run_op(OP_SRL, 32'h8000_0000, 32'd31, 1'b0, 0);
        run_op(OP_NOT, 32'd0, 32'h1234_5678, 1'b0, 0);
        run_op(4'b1010, 32'hDEAD_BEEF, 32'h1, 1'b0, 0);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 0);
        run_op(OP_OR,  32'hF000_0000, 32'h0000_000F, 1'b0, 0);

        // ADD pulsed during cycle 10 of a MUL must be dropped.
        run_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10);
        repeat (3) begin
            @(negedge clk);
            chk("no_queued_done", 64'(done), 64'(0));
        end

        // Reset during cycle 20 of a DIV.
        alucontrol = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (19) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_no_done", 64'(dn), 64'(0));
        chk_all_zero("abort");
        clear_prev();
        run_op(OP_ADD, 32'd3, 32'd4, 1'b0, 0);

        // start held high: single-cycle ops accepted every second cycle.
        alucontrol = OP_ADD; a = 32'd10; b = 32'd20; start = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        start = 1'b0;
        chk("b2b_accepts", 64'(cnt), 64'(3));
        chk("b2b_result",  64'(result), 64'(30));
        chk("b2b_hi",      64'(hi), 64'(0));
        prev_res = 32'd30; prev_hi = '0; prev_zero = 1'b0; prev_dz = 1'b0; prev_ill = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            rop = 4'($urandom_range(0, 15));
            rx  = $urandom;
            case ($urandom_range(0, 7))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = rx;
                default: ry = $urandom;
            endcase
            run_op(rop, rx, ry, 1'b1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
